// File: rtl/paddle_ai_if.sv
// Paddle AI signal bundle: ball-controller observations in, paddle position out.
//   enable      1 = AI drives the paddle, 0 = paddle frozen
//   ball_xpos   ball left x (11b, unsigned)
//   ball_ypos   ball top y (11b, unsigned)
//   score_flag  single-cycle serve/score pulse from the ball controller
//   rect_y_pos  paddle top y (11b)
//   ai_state    00 IDLE, 01 RETURN, 10 TRACK
//   moving      high for the cycle after rect_y_pos changed
// master: ball-controller side; slave: paddle_ai_ctl side.
interface paddle_ai_if;
  logic        enable;
  logic [10:0] ball_xpos;
  logic [10:0] ball_ypos;
  logic        score_flag;
  logic [10:0] rect_y_pos;
  logic [1:0]  ai_state;
  logic        moving;

  modport master (
    output enable, ball_xpos, ball_ypos, score_flag,
    input  rect_y_pos, ai_state, moving
  );

  modport slave (
    input  enable, ball_xpos, ball_ypos, score_flag,
    output rect_y_pos, ai_state, moving
  );
endinterface

// File: rtl/paddle_ai_ctl.sv
// Computer-controlled right-hand paddle. Tracks the ball at a rate-limited
// speed (one movement tick every STEP_DIV clocks) so the CPU can miss.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset (paddle snaps to HOME_Y, state IDLE)
//   bus   paddle_ai_if.slave: enable, ball_xpos, ball_ypos, score_flag in;
//         rect_y_pos, ai_state, moving out (all outputs registered)
// Build option: define PADDLE_AI_ACCEL_EN to allow 2 px steps in TRACK when
// the paddle is far (> 4*DEADZONE and > 2 px) from its target.
module paddle_ai_ctl #(
  parameter int unsigned SCREEN_H  = 600,
  parameter int unsigned PADDLE_H  = 100,
  parameter int unsigned BALL_SIZE = 10,
  parameter int unsigned HOME_Y    = 250,
  parameter int unsigned REACT_X   = 400,
  parameter int unsigned DEADZONE  = 8,
  parameter int unsigned STEP_DIV  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  paddle_ai_if.slave  bus
);

  localparam int unsigned DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [10:0] HOME  = 11'(HOME_Y);
  localparam logic [10:0] Y_MAX = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] REACT = 11'(REACT_X);
  localparam int T_OFS = int'(BALL_SIZE / 2) - int'(PADDLE_H / 2);
  localparam logic signed [11:0] T_OFS12 = 12'(T_OFS);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RETURN = 2'b01,
    TRACK  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       y_q, y_d;
  logic              moving_q;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [10:0]       xpos_q, xpos_d;
  logic              appr_q, appr_d;

  logic              tick;
  logic              appr_upd;
  logic signed [11:0] t_raw;
  logic [10:0]       target;
  logic signed [11:0] err;
  logic [11:0]       abs_err;
  logic [10:0]       step;

  assign tick = (cnt_q == DIV_LAST);

  // Direction is judged against the x sampled on the previous tick; an
  // unchanged x keeps the previous verdict.
  always_comb begin
    if (bus.ball_xpos > xpos_q)      appr_upd = 1'b1;
    else if (bus.ball_xpos < xpos_q) appr_upd = 1'b0;
    else                             appr_upd = appr_q;
  end

  // Target is the paddle top that centres the paddle on the ball centre,
  // clamped so the paddle stays on screen; this clamp is what keeps every
  // TRACK move inside [0, Y_MAX].
  always_comb begin
    t_raw = $signed({1'b0, bus.ball_ypos}) + T_OFS12;
    if (t_raw[11])                              target = '0;
    else if (t_raw > $signed({1'b0, Y_MAX}))    target = Y_MAX;
    else                                        target = t_raw[10:0];
    err     = $signed({1'b0, target}) - $signed({1'b0, y_q});
    abs_err = err[11] ? 12'(-err) : 12'(err);
`ifdef PADDLE_AI_ACCEL_EN
    // Double step only while well outside the deadzone and more than 2 px
    // away, so a 2 px step can never jump past the target.
    step = (abs_err > 12'(4 * DEADZONE) && abs_err > 12'd2) ? 11'd2 : 11'd1;
`else
    step = 11'd1;
`endif
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    xpos_d  = xpos_q;
    appr_d  = appr_q;

    if (!bus.enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = RETURN;
      cnt_d   = '0;
    end else if (bus.score_flag) begin
      y_d     = HOME;
      state_d = RETURN;
      appr_d  = 1'b0;
      cnt_d   = '0;
    end else if (tick) begin
      xpos_d = bus.ball_xpos;
      appr_d = appr_upd;
      case (state_q)
        RETURN: begin
          if (bus.ball_xpos >= REACT && appr_upd) state_d = TRACK;
          else if (y_q < HOME)                     y_d = y_q + 11'd1;
          else if (y_q > HOME)                     y_d = y_q - 11'd1;
        end
        TRACK: begin
          if (bus.ball_xpos < REACT || !appr_upd) state_d = RETURN;
          else if (abs_err > 12'(DEADZONE))       y_d = err[11] ? y_q - step : y_q + step;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      y_q      <= HOME;
      moving_q <= 1'b0;
      cnt_q    <= '0;
      xpos_q   <= '0;
      appr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      moving_q <= (y_d != y_q);
      cnt_q    <= cnt_d;
      xpos_q   <= xpos_d;
      appr_q   <= appr_d;
    end
  end

  assign bus.rect_y_pos = y_q;
  assign bus.ai_state   = state_q;
  assign bus.moving     = moving_q;

endmodule

// File: tb/tb_paddle_ai_ctl.sv
// Testbench for paddle_ai_ctl: two instances (DEADZONE 8 and 0, STEP_DIV 4)
// share the same stimulus. A reference model predicts each cycle's outputs,
// which are queued and compared by a separate monitor after each clock edge.
module tb_paddle_ai_ctl;
  localparam int STEP  = 4;
  localparam int HOME  = 250;
  localparam int YMAX  = 500;
  localparam int REACT = 400;
  localparam int OFS   = 10 / 2 - 100 / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  paddle_ai_if bus0();
  paddle_ai_if bus1();

  paddle_ai_ctl #(.STEP_DIV(4)) u_dz8 (.clk(clk), .rst(rst), .bus(bus0));
  paddle_ai_ctl #(.STEP_DIV(4), .DEADZONE(0)) u_dz0 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int y; int st; int phase; int xq; bit appr; bit mv;
  } mdl_t;

  typedef struct { int y; int st; bit mv; } exp_t;

  mdl_t m0, m1;
  exp_t q0[$], q1[$];
  int checks = 0;
  int errors = 0;
  int mv_cnt0 = 0;

  int bx, by;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.y = HOME; r.st = 0; r.phase = 0; r.xq = 0; r.appr = 0; r.mv = 0;
    return r;
  endfunction

  // Behavioural rules: phase counts clocks since the last tick (or since the
  // divider was cleared); every STEP-th clock in an active state is a tick.
  function automatic mdl_t mdl_step(mdl_t m, int dz, bit en, bit sf, int x, int yb);
    mdl_t n;
    int tgt, err, mag, stp;
    n = m;
    if (!en) begin
      n.st = 0; n.phase = 0;
    end else if (m.st == 0) begin
      n.st = 1; n.phase = 0;
    end else if (sf) begin
      n.y = HOME; n.st = 1; n.appr = 0; n.phase = 0;
    end else if (m.phase + 1 < STEP) begin
      n.phase = m.phase + 1;
    end else begin
      n.phase = 0;
      if (x > m.xq) n.appr = 1;
      else if (x < m.xq) n.appr = 0;
      n.xq = x;
      tgt = yb + OFS;
      if (tgt < 0) tgt = 0;
      if (tgt > YMAX) tgt = YMAX;
      err = tgt - m.y;
      mag = (err < 0) ? -err : err;
      if (m.st == 1) begin
        if (x >= REACT && n.appr) n.st = 2;
        else if (m.y != HOME) n.y = m.y + ((m.y < HOME) ? 1 : -1);
      end else begin
        if (x < REACT || !n.appr) n.st = 1;
        else if (mag > dz) begin
          stp = 1;
`ifdef PADDLE_AI_ACCEL_EN
          if (mag > 4 * dz && mag > 2) stp = 2;
`endif
          n.y = m.y + ((err < 0) ? -stp : stp);
        end
      end
    end
    n.mv = (n.y != m.y);
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Drive one clock's inputs at a falling edge, predict, then wait a cycle.
  task automatic cycle(input bit en, input bit sf, input int x, input int yb);
    exp_t e;
    bus0.enable = en; bus0.score_flag = sf;
    bus0.ball_xpos = 11'(x); bus0.ball_ypos = 11'(yb);
    bus1.enable = en; bus1.score_flag = sf;
    bus1.ball_xpos = 11'(x); bus1.ball_ypos = 11'(yb);
    m0 = mdl_step(m0, 8, en, sf, x, yb);
    m1 = mdl_step(m1, 0, en, sf, x, yb);
    e.y = m0.y; e.st = m0.st; e.mv = m0.mv; q0.push_back(e);
    e.y = m1.y; e.st = m1.st; e.mv = m1.mv; q1.push_back(e);
    @(negedge clk);
    if (bus0.moving) mv_cnt0++;
  endtask

  // Reset is raised between clock edges to exercise the asynchronous path.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_y_dz8", int'(bus0.rect_y_pos), HOME);
    chk("rst_st_dz8", int'(bus0.ai_state), 0);
    chk("rst_mv_dz8", int'(bus0.moving), 0);
    chk("rst_y_dz0", int'(bus1.rect_y_pos), HOME);
    chk("rst_st_dz0", int'(bus1.ai_state), 0);
    q0.delete(); q1.delete();
    m0 = mdl_reset(); m1 = mdl_reset();
    @(negedge clk);
    rst = 1'b0;
    mv_cnt0 = 0;
  endtask

  task automatic cmp(input string nm, input int ay, input int ast, input int amv, input exp_t e);
    checks++;
    if (ay != e.y || ast != e.st || amv != int'(e.mv)) begin
      errors++;
      $display("FAIL %s @%0t: got y=%0d st=%0d mv=%0d expected y=%0d st=%0d mv=%0d",
               nm, $time, ay, ast, amv, e.y, e.st, int'(e.mv));
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp("sb_dz8", int'(bus0.rect_y_pos), int'(bus0.ai_state), int'(bus0.moving), e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("sb_dz0", int'(bus1.rect_y_pos), int'(bus1.ai_state), int'(bus1.moving), e);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_y, len, mode, ylist;
    bit en, sf;
    m0 = mdl_reset(); m1 = mdl_reset();
    bus0.enable = 1'b0; bus0.score_flag = 1'b0; bus0.ball_xpos = '0; bus0.ball_ypos = '0;
    bus1.enable = 1'b0; bus1.score_flag = 1'b0; bus1.ball_xpos = '0; bus1.ball_ypos = '0;
    @(negedge clk);
    do_reset();

    // Ball far away and static: paddle returns home and never moves.
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 200, 300);
    chk("static_st", int'(bus0.ai_state), 1);
    chk("static_y", int'(bus0.rect_y_pos), HOME);
    chk("static_mv_cnt", mv_cnt0, 0);

    // Approaching ball low on screen: track to within the deadzone of 455.
    do_reset();
    bx = 400;
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 == 0) bx++;
      cycle(1'b1, 1'b0, bx, 500);
    end
    chk("track_st", int'(bus0.ai_state), 2);
    chk("track_y_dz8", int'(bus0.rect_y_pos), 447);
    chk("track_y_dz0", int'(bus1.rect_y_pos), 455);
`ifndef PADDLE_AI_ACCEL_EN
    chk("track_mv_cnt", mv_cnt0, 197);
`endif

    // Score pulse snaps home; a receding ball keeps the AI in RETURN.
    cycle(1'b1, 1'b1, bx, 500);
    chk("score_y", int'(bus0.rect_y_pos), HOME);
    chk("score_st", int'(bus0.ai_state), 1);
    chk("score_mv", int'(bus0.moving), 1);
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) bx--;
      cycle(1'b1, 1'b0, bx, 500);
    end
    chk("recede_st", int'(bus0.ai_state), 1);

    // Clamp boundaries: top of screen, then bottom.
    do_reset();
    bx = 400;
    for (int i = 0; i < 1200; i++) begin
      if (i % 4 == 0) bx++;
      cycle(1'b1, 1'b0, bx, 0);
    end
    chk("clamp_lo_dz0", int'(bus1.rect_y_pos), 0);
    chk("clamp_lo_dz8", int'(bus0.rect_y_pos), 8);
    for (int i = 0; i < 2200; i++) begin
      if (i % 4 == 0) bx++;
      cycle(1'b1, 1'b0, bx, 1000);
    end
    chk("clamp_hi_dz0", int'(bus1.rect_y_pos), YMAX);
    chk("clamp_hi_dz8", int'(bus0.rect_y_pos), YMAX - 8);

    // Disable mid-track freezes the paddle; reset mid-move snaps home.
    do_reset();
    bx = 400;
    for (int i = 0; i < 80; i++) begin
      if (i % 4 == 0) bx++;
      cycle(1'b1, 1'b0, bx, 500);
    end
    hold_y = int'(bus0.rect_y_pos);
    cycle(1'b0, 1'b0, bx, 500);
    chk("disable_st", int'(bus0.ai_state), 0);
    chk("disable_y", int'(bus0.rect_y_pos), hold_y);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, bx + i * 3, 500);
    chk("frozen_y", int'(bus0.rect_y_pos), hold_y);
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) bx++;
      cycle(1'b1, 1'b0, bx, 500);
    end
    do_reset();

    // Randomized phases against the reference model.
    for (int p = 0; p < 60; p++) begin
      len  = $urandom_range(50, 400);
      mode = $urandom_range(0, 3);
      ylist = $urandom_range(0, 3);
      by = (ylist == 0) ? 0 : (ylist == 1) ? 500 : (ylist == 2) ? 1000 : $urandom_range(0, 2047);
      bx = $urandom_range(300, 600);
      for (int i = 0; i < len; i++) begin
        if (mode == 0 && i % 4 == 0) bx = bx + $urandom_range(1, 3);
        else if (mode == 1 && i % 4 == 0) bx = bx - $urandom_range(1, 3);
        else if (mode == 3) bx = $urandom_range(0, 2047);
        if (bx < 0) bx = 0;
        if (bx > 2047) bx = 2047;
        if ($urandom_range(0, 49) == 0) by = $urandom_range(0, 2047);
        sf = ($urandom_range(0, 199) == 0);
        en = ($urandom_range(0, 149) != 0);
        cycle(en, sf, bx, by);
      end
      if ($urandom_range(0, 7) == 0) do_reset();
    end

    cycle(1'b1, 1'b0, bx, by);
    cycle(1'b1, 1'b0, bx, by);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
